mult32x32_fast: RTL and testbench

Sequential unsigned 32x32 → 64-bit multiplier that uses a single 8x16 multiplier and a 64-bit accumulator, one partial product per clock. It is the "fast" variant: it skips partial products whose operand slices are known to be zero, so small operands finish in fewer cycles. It sits as a standalone arithmetic block driven by a start/busy handshake.

---
 rtl/mult32x32_pkg.sv | 23 ++
 rtl/mult32x32_fast_arith.sv | 55 +++++
 rtl/mult32x32_fast.sv | 112 +++++++++++
 tb/tb_mult32x32_fast.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/mult32x32_pkg.sv
// Shared types and widths for the sequential 32x32 multiplier.
// Slice widths fix the 8x16 partial-product multiplier.
package mult32x32_pkg;

    localparam int unsigned OpW   = 32;
    localparam int unsigned ByteW = 8;
    localparam int unsigned HalfW = 16;
    localparam int unsigned PpW   = ByteW + HalfW;
    localparam int unsigned ProdW = 64;

    typedef enum logic [3:0] {
        StIdle,
        StA0B0,
        StA1B0,
        StA2B0,
        StA3B0,
        StA0B1,
        StA1B1,
        StA2B1,
        StA3B1
    } state_e;

endpackage

// File: rtl/mult32x32_fast_arith.sv
// Datapath: operand registers, slice muxes, 8x16 multiplier, shifter and accumulator.
// The accumulator adds one shifted partial product per enabled cycle.
module mult32x32_fast_arith
    import mult32x32_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_clear,
    input  logic             i_update,
    input  logic [1:0]       i_a_sel,
    input  logic             i_b_sel,
    input  logic [OpW-1:0]   i_a,
    input  logic [OpW-1:0]   i_b,
    output logic [ProdW-1:0] o_product
);

    logic [OpW-1:0]   r_a;
    logic [OpW-1:0]   r_b;
    logic [ProdW-1:0] r_product;

    logic [ByteW-1:0] w_byte;
    logic [HalfW-1:0] w_half;
    logic [PpW-1:0]   w_pp;
    logic [5:0]       w_shamt;
    logic [ProdW-1:0] w_shifted;

    assign w_byte    = r_a[{i_a_sel, 3'b000} +: ByteW];
    assign w_half    = r_b[{i_b_sel, 4'b0000} +: HalfW];
    assign w_pp      = {{HalfW{1'b0}}, w_byte} * {{ByteW{1'b0}}, w_half};
    // Shift is 8*a_sel + 16*b_sel, at most 40.
    assign w_shamt   = {1'b0, i_a_sel, 3'b000} + {1'b0, i_b_sel, 4'b0000};
    assign w_shifted = {{(ProdW - PpW){1'b0}}, w_pp} << w_shamt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_product <= '0;
        end else begin
            if (i_load) begin
                r_a <= i_a;
                r_b <= i_b;
            end
            if (i_clear) begin
                r_product <= '0;
            end else if (i_update) begin
                r_product <= r_product + w_shifted;
            end
        end
    end

    assign o_product = r_product;

endmodule

// File: rtl/mult32x32_fast.sv
// Sequential unsigned 32x32->64 multiplier, one 8x16 partial product per clock.
// Partial products whose operand upper halves are zero are skipped.
module mult32x32_fast
    import mult32x32_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OpW-1:0]   a,
    input  logic [OpW-1:0]   b,
    output logic             busy,
    output logic [ProdW-1:0] product
);

    state_e     r_state;
    state_e     w_state_next;
    logic       r_a_msw_is_0;
    logic       r_b_msw_is_0;
    logic       w_accept;
    logic       w_update;
    logic [1:0] w_a_sel;
    logic       w_b_sel;

    assign w_accept = (r_state == StIdle) && start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= StIdle;
            r_a_msw_is_0 <= 1'b0;
            r_b_msw_is_0 <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_a_msw_is_0 <= (a[OpW-1:HalfW] == '0);
                r_b_msw_is_0 <= (b[OpW-1:HalfW] == '0);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_update     = 1'b0;
        w_a_sel      = 2'd0;
        w_b_sel      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start) w_state_next = StA0B0;
            end
            StA0B0: begin
                w_update     = 1'b1;
                w_state_next = StA1B0;
            end
            StA1B0: begin
                w_update = 1'b1;
                w_a_sel  = 2'd1;
                if (!r_a_msw_is_0)     w_state_next = StA2B0;
                else if (r_b_msw_is_0) w_state_next = StIdle;
                else                   w_state_next = StA0B1;
            end
            StA2B0: begin
                w_update     = 1'b1;
                w_a_sel      = 2'd2;
                w_state_next = StA3B0;
            end
            StA3B0: begin
                w_update     = 1'b1;
                w_a_sel      = 2'd3;
                w_state_next = r_b_msw_is_0 ? StIdle : StA0B1;
            end
            StA0B1: begin
                w_update     = 1'b1;
                w_b_sel      = 1'b1;
                w_state_next = StA1B1;
            end
            StA1B1: begin
                w_update     = 1'b1;
                w_a_sel      = 2'd1;
                w_b_sel      = 1'b1;
                w_state_next = r_a_msw_is_0 ? StIdle : StA2B1;
            end
            StA2B1: begin
                w_update     = 1'b1;
                w_a_sel      = 2'd2;
                w_b_sel      = 1'b1;
                w_state_next = StA3B1;
            end
            StA3B1: begin
                w_update     = 1'b1;
                w_a_sel      = 2'd3;
                w_b_sel      = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign busy = (r_state != StIdle);

    mult32x32_fast_arith u_arith (
        .i_clk     (clk),
        .i_rst     (reset),
        .i_load    (w_accept),
        .i_clear   (w_accept),
        .i_update  (w_update),
        .i_a_sel   (w_a_sel),
        .i_b_sel   (w_b_sel),
        .i_a       (a),
        .i_b       (b),
        .o_product (product)
    );

endmodule

// File: tb/tb_mult32x32_fast.sv
// Directed self-checking bench for mult32x32_fast; inputs driven and outputs
// sampled on the falling edge, away from the active rising edge.
module tb_mult32x32_fast;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [63:0] product;

    int tests = 0;
    int fails = 0;
    int ncyc;

    mult32x32_fast dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the start edge.
    task automatic pulse_start(input logic [31:0] av, input logic [31:0] bv);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts busy cycles from the current one onward, bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic [63:0] exp, input int exp_cyc);
        int n;
        pulse_start(av, bv);
        check({tag, "_clr"}, product, 64'd0);
        wait_idle(n);
        check({tag, "_cyc"}, 64'(n), 64'(exp_cyc));
        check({tag, "_prod"}, product, exp);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (4) begin
            @(negedge clk);
            check("rst_busy", {63'd0, busy}, 64'd0);
            check("rst_prod", product, 64'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_busy", {63'd0, busy}, 64'd0);
        check("post_rst_prod", product, 64'd0);

        run("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 8);
        run("lsw", 32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001, 2);
        run("bskip", 32'h0001_0000, 32'h0000_0003, 64'h0000_0000_0003_0000, 4);
        run("askip", 32'h0000_0003, 32'h0001_0000, 64'h0000_0000_0003_0000, 4);

        // Restart attempt at cycle 3 with new operands must be ignored.
        pulse_start(32'h1234_5678, 32'h9ABC_DEF0);
        repeat (2) @(negedge clk);
        a     = 32'h0000_0005;
        b     = 32'h0000_0007;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = 32'hDEAD_BEEF;
        b     = 32'hCAFE_F00D;
        wait_idle(ncyc);
        check("ign_cyc", 64'(ncyc), 64'd5);
        check("ign_prod", product, 64'h0B00_EA4E_242D_2080);
        repeat (3) @(negedge clk);
        check("hold_prod", product, 64'h0B00_EA4E_242D_2080);

        run("azero", 32'h0000_0000, 32'h1234_5678, 64'd0, 4);

        // Asynchronous reset in cycle 4 of an 8-cycle operation.
        pulse_start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (3) @(negedge clk);
        check("mid_busy", {63'd0, busy}, 64'd1);
        #2 reset = 1'b1;
        #1;
        check("async_busy", {63'd0, busy}, 64'd0);
        check("async_prod", product, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run("r5x7", 32'd5, 32'd7, 64'd35, 2);

        // start held high across completion chains a second operation.
        a     = 32'd3;
        b     = 32'd4;
        start = 1'b1;
        @(negedge clk);
        check("chain_b1", {63'd0, busy}, 64'd1);
        @(negedge clk);
        check("chain_b2", {63'd0, busy}, 64'd1);
        a = 32'd6;
        b = 32'd7;
        @(negedge clk);
        check("chain_idle", {63'd0, busy}, 64'd0);
        check("chain_p1", product, 64'd12);
        @(negedge clk);
        start = 1'b0;
        check("chain_rebusy", {63'd0, busy}, 64'd1);
        wait_idle(ncyc);
        check("chain_cyc", 64'(ncyc), 64'd2);
        check("chain_p2", product, 64'd42);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "timeout");
    end

endmodule
